hdlc_rx_protocol_monitor: RTL and testbench
===========================================

Name: hdlc_rx_protocol_monitor

Overview:
Synthesizable, parametrised protocol checker for CHANNELS independent HDLC receive lanes. It sits beside the Rx datapath and observes each lane's serial input plus its FlagDetect, AbortDetect, ValidFrame and AbortSignal outputs. It flags missing flag detections at a configurable latency and missing abort signalling. It keeps sticky per-lane error bits, a saturating total error count and a first-error capture register that can be read in-system.

Parameters:
CHANNELS, 4, number of monitored Rx lanes (1..16)
FLAG_LAT, 2, cycles from the last flag bit on Rx to the required Rx_FlagDetect (1..8)
CNT_W, 16, width of the total error counter

Ports:
Clk  in  1  clock; all logic on rising edge
Rst  in  1  synchronous, active-high reset
Rx  in  CHANNELS  serial Rx bit per lane
Rx_En  in  CHANNELS  lane enable; a low lane is not checked and its history is cleared
Rx_FlagDetect  in  CHANNELS  DUT flag detect per lane
Rx_AbortDetect  in  CHANNELS  DUT abort detect per lane
Rx_ValidFrame  in  CHANNELS  DUT frame-valid per lane
Rx_AbortSignal  in  CHANNELS  DUT abort signal per lane
ClrErr  in  1  one-cycle pulse; clears counter, sticky bits and capture
ErrCnt  out  CNT_W  total errors, saturating
ErrSticky  out  CHANNELS  per-lane sticky error
ErrPulse  out  1  high one cycle after any error is detected
ErrFirstValid  out  1  capture register holds data
ErrFirstCh  out  4  lane of first error
ErrFirstCode  out  2  01 flag missed, 10 abort missed, 11 spurious flag

Behaviour:
- Reset: ErrCnt=0, ErrSticky=0, ErrPulse=0, ErrFirstValid=0, ErrFirstCh=0, ErrFirstCode=0. All history and delay pipes are cleared to 0.
- Per lane: an 8-bit history shift register, newest bit in bit 0. Flag match when the history equals 0111_1110 (oldest 0, six 1s, newest 0).
- A flag match enters a FLAG_LAT-deep delay pipe. When it reaches the tap, Rx_FlagDetect must be 1 in that cycle; otherwise a flag-miss error (code 01) is raised.
- Abort check: if Rx_AbortDetect && Rx_ValidFrame in cycle n, then Rx_AbortSignal must be 1 in cycle n+1; otherwise an abort-miss error (code 10) is raised. Each qualifying cycle is checked independently.
- Back-to-back flags that share a 0 (0111_1110_1111_110) produce two matches 7 cycles apart. Both are checked.
- Rx_En low: history and pipes for that lane are cleared to 0. No errors are raised for that lane, including pending pipe entries. After re-enable, a flag needs 8 fresh bits.
- Error register stage: errors detected in cycle n update the outputs at the edge ending cycle n. ErrPulse is high during cycle n+1.
- Count: ErrCnt += popcount of errors raised this cycle, counting every lane and check type. The sum saturates at 2^CNT_W-1 and never wraps.
- Capture: loaded only while ErrFirstValid=0. For simultaneous errors, the lowest lane index wins. Within a lane, the priority is 01, then 10, then 11.
- ClrErr together with errors in the same cycle: the clear takes effect first, then that cycle's errors are applied. Result: ErrCnt=popcount, sticky bits and capture reflect only those errors.
- Rst asserted mid-operation discards pending pipe entries. No error is reported for them.

Optional Feature:
SPURIOUS_FLAG_CHK_EN: when defined, any Rx_FlagDetect=1 on an enabled lane with no matching pipe tap in the same cycle raises code 11. When undefined, spurious detections are ignored and code 11 is never produced.

Test Plan:
- Lane 0 receives 0111_1110 and Rx_FlagDetect pulses exactly 2 cycles after the last 0 -> ErrCnt=0, ErrSticky=0, ErrPulse never high.
- Same flag on lane 2 with Rx_FlagDetect held low -> ErrCnt=1, ErrSticky=4'b0100, ErrFirstCh=2, ErrFirstCode=01, ErrPulse high for one cycle.
- Lanes 1 and 3 both have AbortDetect&&ValidFrame with no AbortSignal in the same cycle -> ErrCnt=2, ErrFirstCh=1, ErrFirstCode=10.
- CNT_W=4, 20 flag misses -> ErrCnt holds at 15. ClrErr coincident with one new miss on lane 0 -> ErrCnt=1, ErrFirstCh=0.
- Flag sent on lane 1, then Rx_En[1] dropped before the tap -> no error. Re-enable, then send 7 ones followed by a 0 -> no false match.
- With SPURIOUS_FLAG_CHK_EN defined, FlagDetect pulses on lane 0 with no flag -> ErrFirstCode=11, ErrCnt=1. With the macro undefined -> ErrCnt=0.

Source files
------------

// File: rtl/hdlc_rx_protocol_monitor.sv
// hdlc_rx_protocol_monitor: per-lane HDLC Rx flag/abort checker with sticky errors, saturating count and first-error capture
// Optional: define SPURIOUS_FLAG_CHK_EN to flag Rx_FlagDetect pulses that have no matching flag (code 11).
module hdlc_rx_protocol_monitor #(
    parameter int CHANNELS = 4,
    parameter int FLAG_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [CHANNELS-1:0] Rx,
    input  logic [CHANNELS-1:0] Rx_En,
    input  logic [CHANNELS-1:0] Rx_FlagDetect,
    input  logic [CHANNELS-1:0] Rx_AbortDetect,
    input  logic [CHANNELS-1:0] Rx_ValidFrame,
    input  logic [CHANNELS-1:0] Rx_AbortSignal,
    input  logic                ClrErr,
    output logic [CNT_W-1:0]    ErrCnt,
    output logic [CHANNELS-1:0] ErrSticky,
    output logic                ErrPulse,
    output logic                ErrFirstValid,
    output logic [3:0]          ErrFirstCh,
    output logic [1:0]          ErrFirstCode
);
    localparam logic [CNT_W+5:0] CNT_MAX = (CNT_W+6)'({CNT_W{1'b1}});

    // The 8-bit flag window is the 7 stored bits plus the bit on Rx this cycle.
    logic [6:0]          hist [CHANNELS];
    logic [FLAG_LAT-1:0] pipe [CHANNELS];
    logic [CHANNELS-1:0] abort_pend, match, tap, err_flag, err_abort, err_spur, lane_err;
    logic [5:0]          pop;
    logic [3:0]          first_ch;
    logic [1:0]          first_code;
    logic [CNT_W+5:0]    cnt_sum;
    logic [CHANNELS-1:0] sticky_base;
    logic                valid_base;

    // Per-lane flag match and error detection for the current cycle
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            match[i]     = Rx_En[i] && ({hist[i], Rx[i]} == 8'h7E);
            tap[i]       = pipe[i][FLAG_LAT-1];
            err_flag[i]  = Rx_En[i] && tap[i] && !Rx_FlagDetect[i];
            err_abort[i] = Rx_En[i] && abort_pend[i] && !Rx_AbortSignal[i];
`ifdef SPURIOUS_FLAG_CHK_EN
            err_spur[i]  = Rx_En[i] && Rx_FlagDetect[i] && !tap[i];
`else
            err_spur[i]  = 1'b0;
`endif
            lane_err[i]  = err_flag[i] || err_abort[i] || err_spur[i];
        end
    end

    // Error popcount and lowest-lane first-error selection; clear applies before new errors
    always_comb begin
        pop        = '0;
        first_ch   = '0;
        first_code = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            pop = pop + 6'(err_flag[i]) + 6'(err_abort[i]) + 6'(err_spur[i]);
            if (lane_err[i]) begin
                first_ch   = 4'(i);
                first_code = err_flag[i] ? 2'b01 : err_abort[i] ? 2'b10 : 2'b11;
            end
        end
        cnt_sum     = (CNT_W+6)'(ClrErr ? '0 : ErrCnt) + (CNT_W+6)'(pop);
        sticky_base = ClrErr ? '0 : ErrSticky;
        valid_base  = ErrFirstValid && !ClrErr;
    end

    // Lane history, flag delay pipe and pending abort check; a disabled lane forgets everything
    always_ff @(posedge Clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (Rst || !Rx_En[i]) begin
                hist[i]       <= '0;
                pipe[i]       <= '0;
                abort_pend[i] <= 1'b0;
            end else begin
                hist[i]       <= {hist[i][5:0], Rx[i]};
                pipe[i]       <= FLAG_LAT'({pipe[i], match[i]});
                abort_pend[i] <= Rx_AbortDetect[i] && Rx_ValidFrame[i];
            end
        end
    end

    // Error reporting registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ErrCnt        <= '0;
            ErrSticky     <= '0;
            ErrPulse      <= 1'b0;
            ErrFirstValid <= 1'b0;
            ErrFirstCh    <= '0;
            ErrFirstCode  <= '0;
        end else begin
            ErrCnt        <= (cnt_sum > CNT_MAX) ? '1 : CNT_W'(cnt_sum);
            ErrSticky     <= sticky_base | lane_err;
            ErrPulse      <= |lane_err;
            ErrFirstValid <= valid_base || (|lane_err);
            ErrFirstCh    <= (!valid_base && |lane_err) ? first_ch : ClrErr ? '0 : ErrFirstCh;
            ErrFirstCode  <= (!valid_base && |lane_err) ? first_code : ClrErr ? '0 : ErrFirstCode;
        end
    end
endmodule

// File: tb/tb_hdlc_rx_protocol_monitor.sv
// tb_hdlc_rx_protocol_monitor: scoreboard bench with a lane-level reference model of the Rx monitor
module tb_hdlc_rx_protocol_monitor;
    localparam int CH  = 4;
    localparam int LAT = 2;
    localparam int CW  = 4;

    logic          clk = 0;
    logic          rst = 1, clr = 0;
    logic [CH-1:0] rx = 0, en = 0, fd = 0, ad = 0, vf = 0, as_sig = 0;
    logic [CW-1:0] err_cnt;
    logic [CH-1:0] err_sticky;
    logic          err_pulse, err_first_valid;
    logic [3:0]    err_first_ch;
    logic [1:0]    err_first_code;

    hdlc_rx_protocol_monitor #(.CHANNELS(CH), .FLAG_LAT(LAT), .CNT_W(CW)) dut (
        .Clk(clk), .Rst(rst), .Rx(rx), .Rx_En(en), .Rx_FlagDetect(fd),
        .Rx_AbortDetect(ad), .Rx_ValidFrame(vf), .Rx_AbortSignal(as_sig), .ClrErr(clr),
        .ErrCnt(err_cnt), .ErrSticky(err_sticky), .ErrPulse(err_pulse),
        .ErrFirstValid(err_first_valid), .ErrFirstCh(err_first_ch), .ErrFirstCode(err_first_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int cnt;
        int sticky;
        int pulse;
        int fv;
        int fch;
        int fcode;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    // Reference model: recent bits per lane, cycles at which a detect is owed, cycle an abort signal is owed
    int bits_q[CH][$];
    int due_q[CH][$];
    int abort_due[CH];
    int src_q[CH][$];
    int e_cnt = 0, e_sticky = 0, e_pulse = 0, e_fv = 0, e_fch = 0, e_fcode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("ErrCnt", 32'(err_cnt), e.cnt);
            chk("ErrSticky", 32'(err_sticky), e.sticky);
            chk("ErrPulse", 32'(err_pulse), e.pulse);
            chk("ErrFirstValid", 32'(err_first_valid), e.fv);
            chk("ErrFirstCh", 32'(err_first_ch), e.fch);
            chk("ErrFirstCode", 32'(err_first_code), e.fcode);
        end
    end

    function automatic bit owed(int c, int n);
        foreach (due_q[c][k]) if (due_q[c][k] == n) return 1;
        return 0;
    endfunction

    function automatic void lane_clear(int c);
        bits_q[c] = '{0, 0, 0, 0, 0, 0, 0, 0};
        due_q[c].delete();
        abort_due[c] = -1;
    endfunction

    task automatic step(bit r, bit cl, logic [CH-1:0] en_v, rx_v, fd_v, ad_v, vf_v, as_v);
        int n, total, w, code;
        bit f, a, s, req;
        n = cyc;
        rst = r; clr = cl; en = en_v; rx = rx_v; fd = fd_v; ad = ad_v; vf = vf_v; as_sig = as_v;
        if (r) begin
            for (int c = 0; c < CH; c++) lane_clear(c);
            e_cnt = 0; e_sticky = 0; e_pulse = 0; e_fv = 0; e_fch = 0; e_fcode = 0;
        end else begin
            if (cl) begin
                e_cnt = 0; e_sticky = 0; e_fv = 0; e_fch = 0; e_fcode = 0;
            end
            total = 0;
            for (int c = 0; c < CH; c++) begin
                req = en_v[c] && owed(c, n);
                f = req && !fd_v[c];
                a = en_v[c] && abort_due[c] == n && !as_v[c];
`ifdef SPURIOUS_FLAG_CHK_EN
                s = en_v[c] && fd_v[c] && !req;
`else
                s = 0;
`endif
                total += int'(f) + int'(a) + int'(s);
                if (f || a || s) begin
                    e_sticky |= (1 << c);
                    code = f ? 1 : a ? 2 : 3;
                    if (!e_fv) begin
                        e_fv = 1; e_fch = c; e_fcode = code;
                    end
                end
            end
            e_cnt = (e_cnt + total > (1 << CW) - 1) ? (1 << CW) - 1 : e_cnt + total;
            e_pulse = total > 0;
            for (int c = 0; c < CH; c++) begin
                if (!en_v[c]) lane_clear(c);
                else begin
                    bits_q[c].push_back(int'(rx_v[c]));
                    void'(bits_q[c].pop_front());
                    w = 0;
                    foreach (bits_q[c][k]) w = w * 2 + bits_q[c][k];
                    while (due_q[c].size() > 0 && due_q[c][0] <= n) void'(due_q[c].pop_front());
                    if (w == 'h7E) due_q[c].push_back(n + LAT);
                    abort_due[c] = (ad_v[c] && vf_v[c]) ? n + 1 : -1;
                end
            end
        end
        sb.push_back('{n + 1, e_cnt, e_sticky, e_pulse, e_fv, e_fch, e_fcode});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int k);
        for (int i = 0; i < k; i++) step(0, 0, 4'hF, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        logic [CH-1:0] rv, fv, av, vv, sv, ev;
        bit done;
        pat = 8'h7E;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
        // Good flag on lane 0 with detect exactly FLAG_LAT after the last 0
        for (int i = 0; i < 11; i++) step(0, 0, 4'hF, (i < 8) ? {3'b0, pat[7-i]} : 4'b0001, {3'b0, i == 9}, 0, 0, 0);
        idle(3);
        // Flag on lane 2 with detect held low
        for (int i = 0; i < 8; i++) step(0, 0, 4'hF, {1'b0, pat[7-i], 2'b0}, 0, 0, 0, 0);
        idle(4);
        // Simultaneous abort misses on lanes 1 and 3
        step(0, 1, 4'hF, 0, 0, 0, 0, 0);
        step(0, 0, 4'hF, 0, 0, 4'b1010, 4'b1010, 0);
        idle(3);
        // Back-to-back shared-0 flags on lane 0 saturate the counter, then clear meets a miss
        step(0, 1, 4'hF, 0, 0, 0, 0, 0);
        done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            done = (k > 160) && owed(0, cyc);
            step(0, done, 4'hF, {3'b0, (k == 0) ? 1'b0 : ((k - 1) % 7 != 6)}, 0, 0, 0, 0);
        end
        idle(4);
        // Lane 1 disabled before its tap, then 7 ones and a 0 after re-enable
        step(0, 1, 4'hF, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 4'hF, {2'b0, pat[7-i], 1'b0}, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 4'b1101, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 4'hF, {2'b0, i < 7, 1'b0}, 0, 0, 0, 0);
        idle(4);
        // Detect pulse on lane 0 with no flag
        step(0, 1, 4'hF, 0, 0, 0, 0, 0);
        step(0, 0, 4'hF, 0, 4'b0001, 0, 0, 0);
        idle(3);
        // Randomized traffic with cooperative detects and occasional faults
        ev = 4'hF;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(49) == 0) ev[c] = ~ev[c];
                if (src_q[c].size() == 0) begin
                    if ($urandom_range(1) == 0) for (int b = 7; b >= 0; b--) src_q[c].push_back(int'(pat[b]));
                    else for (int b = 0; b < 8; b++) src_q[c].push_back(int'($urandom_range(1)));
                end
                rv[c] = src_q[c].pop_front() != 0;
                fv[c] = owed(c, cyc) ^ ($urandom_range(9) == 0) ^ ($urandom_range(99) == 0);
                av[c] = $urandom_range(7) == 0;
                vv[c] = $urandom_range(3) != 0;
                sv[c] = (abort_due[c] == cyc) ^ ($urandom_range(7) == 0);
            end
            step($urandom_range(199) == 0, $urandom_range(39) == 0, ev, rv, fv, av, vv, sv);
        end
        idle(3);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
